// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: runs a req/ack fetch for the current PC and registers
// the result into IF/ID, with a one-entry stall buffer and flush-drain handling.
module if_fetch_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              keep_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              ifid_valid_o,
  output logic [ADDR_W-1:0] ifid_pc_o,
  output logic [ADDR_W-1:0] ifid_pc4_o,
  output logic [DATA_W-1:0] ifid_instr_o
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pc4_q, pc4_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   buf_pc_q, buf_pc_d;
  logic [DATA_W-1:0]   buf_instr_q, buf_instr_d;
  logic                keep_c;

  // Next-state, IF/ID load and PC-hold decision
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    valid_d     = stall_i ? valid_q : 1'b0;
    pc_d        = pc_q;
    instr_d     = instr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    keep_c      = 1'b1;

    unique case (state_q)
      S_ISSUE: begin
        if (!flush_i) begin
          req_d   = 1'b1;
          addr_d  = pc_i;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          if (imem_ack_i) begin
            req_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (imem_ack_i) begin
          req_d = 1'b0;
          if (!stall_i || !valid_q) begin
            valid_d = 1'b1;
            pc_d    = addr_q;
            instr_d = imem_rdata_i;
            keep_c  = 1'b0;
            state_d = S_ISSUE;
          end else begin
            buf_pc_d    = addr_q;
            buf_instr_d = imem_rdata_i;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          state_d = S_ISSUE;
        end else if (!stall_i) begin
          valid_d = 1'b1;
          pc_d    = buf_pc_q;
          instr_d = buf_instr_q;
          keep_c  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase

    // A redirect overrides stall and ack: kill IF/ID and let the PC load the target
    if (flush_i) begin
      valid_d = 1'b0;
      keep_c  = 1'b0;
    end

    pc4_d = pc_d + ADDR_W'(4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_ISSUE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      pc4_q       <= ADDR_W'(4);
      instr_q     <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      instr_q     <= instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign keep_o       = keep_c;
  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign ifid_valid_o = valid_q;
  assign ifid_pc_o    = pc_q;
  assign ifid_pc4_o   = pc4_q;
  assign ifid_instr_o = instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: cycle-accurate checks plus a scoreboard of
// instructions expected to appear in IF/ID, in order.
module tb_if_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        stall_i, flush_i, imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        keep_o, imem_req_o, ifid_valid_o;
  logic [31:0] imem_addr_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o;

  if_fetch_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .keep_o       (keep_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .ifid_valid_o (ifid_valid_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .ifid_instr_o (ifid_instr_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] sb_q[$];
  logic        pc_upd = 1'b0;
  logic [31:0] pc_nxt = '0;
  logic [31:0] tgt    = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, then model the PC register reacting to keep_o
  task automatic step(input logic st, input logic fl, input logic ak, input logic [31:0] rd);
    @(negedge clk_i);
    if (pc_upd) begin
      pc_i   = pc_nxt;
      pc_upd = 1'b0;
    end
    stall_i      = st;
    flush_i      = fl;
    imem_ack_i   = ak;
    imem_rdata_i = rd;
    #1;
    if (!keep_o && !rst_i) begin
      pc_upd = 1'b1;
      pc_nxt = fl ? tgt : pc_i + 32'd4;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   64'(imem_req_o),   64'd0);
    chk({tag, "_addr"},  64'(imem_addr_o),  64'd0);
    chk({tag, "_valid"}, 64'(ifid_valid_o), 64'd0);
    chk({tag, "_pc"},    64'(ifid_pc_o),    64'd0);
    chk({tag, "_pc4"},   64'(ifid_pc4_o),   64'd4);
    chk({tag, "_instr"}, 64'(ifid_instr_o), 64'd0);
    chk({tag, "_keep"},  64'(keep_o),       64'd1);
  endtask

  // Scoreboard monitor: every new IF/ID content must match the oldest expected entry
  logic        prev_valid = 1'b0;
  logic [63:0] prev_ifid  = '0;
  always @(negedge clk_i) begin
    if (ifid_valid_o && (!prev_valid || prev_ifid != {ifid_pc_o, ifid_instr_o})) begin
      if (sb_q.size() == 0) chk("sb_unexpected", {ifid_pc_o, ifid_instr_o}, 64'd0);
      else                  chk("sb_ifid", {ifid_pc_o, ifid_instr_o}, sb_q.pop_front());
    end
    prev_valid <= ifid_valid_o;
    prev_ifid  <= {ifid_pc_o, ifid_instr_o};
  end

  initial begin
    rst_i = 1'b1; pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    repeat (3) step(0, 0, 0, 32'h0);
    chk_reset_vals("rst");
    rst_i = 1'b0;

    // Zero-wait fetch at PC 0
    step(0, 0, 1, 32'h2008_0005);
    sb_q.push_back({32'h0, 32'h2008_0005});
    chk("zw_req", 64'(imem_req_o), 64'd1);
    chk("zw_addr", 64'(imem_addr_o), 64'd0);
    chk("zw_keep", 64'(keep_o), 64'd0);
    step(0, 0, 0, 32'h0);
    chk("zw_valid", 64'(ifid_valid_o), 64'd1);
    chk("zw_instr", 64'(ifid_instr_o), 64'h2008_0005);
    chk("zw_pc4", 64'(ifid_pc4_o), 64'd4);
    chk("zw_keep_issue", 64'(keep_o), 64'd1);

    // Three-cycle memory latency at PC 4
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0);
      chk("lat_addr", 64'(imem_addr_o), 64'd4);
      chk("lat_keep", 64'(keep_o), 64'd1);
    end
    chk("lat_bubble", 64'(ifid_valid_o), 64'd0);
    step(0, 0, 1, 32'h1111_1111);
    sb_q.push_back({32'h4, 32'h1111_1111});
    chk("lat_keep_ack", 64'(keep_o), 64'd0);
    step(1, 0, 0, 32'h0);
    chk("lat_req_drop", 64'(imem_req_o), 64'd0);
    chk("lat_instr", 64'(ifid_instr_o), 64'h1111_1111);

    // Stall when ack returns: buffered, then released
    step(1, 0, 1, 32'h2222_2222);
    sb_q.push_back({32'h8, 32'h2222_2222});
    chk("st_keep_ack", 64'(keep_o), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 32'h0);
      chk("st_keep_hold", 64'(keep_o), 64'd1);
      chk("st_instr_hold", 64'(ifid_instr_o), 64'h1111_1111);
      chk("st_valid_hold", 64'(ifid_valid_o), 64'd1);
    end
    step(0, 0, 0, 32'h0);
    chk("st_keep_rel", 64'(keep_o), 64'd0);
    step(0, 0, 0, 32'h0);
    chk("st_instr_new", 64'(ifid_instr_o), 64'h2222_2222);
    chk("st_pc4_new", 64'(ifid_pc4_o), 64'd12);

    // Flush during WAIT; late ack must be drained, not delivered
    tgt = 32'h100;
    step(0, 1, 0, 32'h0);
    chk("fl_keep", 64'(keep_o), 64'd0);
    step(0, 0, 0, 32'h0);
    chk("fl_valid", 64'(ifid_valid_o), 64'd0);
    chk("fl_keep_drain", 64'(keep_o), 64'd1);
    chk("fl_addr_stable", 64'(imem_addr_o), 64'd12);
    step(0, 0, 1, 32'hDEAD_BEEF);
    chk("fl_keep_drain_ack", 64'(keep_o), 64'd1);
    step(0, 0, 0, 32'h0);
    chk("fl_valid_after", 64'(ifid_valid_o), 64'd0);
    step(0, 0, 1, 32'h3333_3333);
    sb_q.push_back({32'h100, 32'h3333_3333});
    chk("fl_target_addr", 64'(imem_addr_o), 64'h100);
    step(1, 0, 0, 32'h0);

    // Flush, stall and ack together
    tgt = 32'h200;
    step(1, 1, 1, 32'h4444_4444);
    chk("fsa_keep", 64'(keep_o), 64'd0);
    step(0, 0, 0, 32'h0);
    chk("fsa_valid", 64'(ifid_valid_o), 64'd0);
    chk("fsa_req", 64'(imem_req_o), 64'd0);
    step(0, 0, 0, 32'h0);
    chk("fsa_issue_addr", 64'(imem_addr_o), 64'h200);

    // Wrap-around of PC+4
    step(0, 0, 1, 32'h5555_5555);
    sb_q.push_back({32'h200, 32'h5555_5555});
    pc_nxt = 32'hFFFF_FFFC;
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h6666_6666);
    sb_q.push_back({32'hFFFF_FFFC, 32'h6666_6666});
    chk("wr_addr", 64'(imem_addr_o), 64'hFFFF_FFFC);
    step(0, 0, 0, 32'h0);
    chk("wr_pc", 64'(ifid_pc_o), 64'hFFFF_FFFC);
    chk("wr_pc4", 64'(ifid_pc4_o), 64'h0);

    // Reset during WAIT abandons the request
    step(0, 0, 0, 32'h0);
    chk("rw_req", 64'(imem_req_o), 64'd1);
    rst_i = 1'b1;
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk_reset_vals("rst2");

    // Recovery fetch after reset
    pc_i = 32'h80;
    rst_i = 1'b0;
    step(0, 0, 1, 32'h7777_7777);
    sb_q.push_back({32'h80, 32'h7777_7777});
    chk("rc_addr", 64'(imem_addr_o), 64'h80);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("sb_left", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
